// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin arbiter sharing one CORDIC core among NUM_REQ requesters
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESPOND, with a WAIT timeout.
module cordic_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int TIMEOUT_WIDTH    = 10,
  parameter int TIMEOUT_MAX      = 1023
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ*FLOAT_DATA_WIDTH-1:0] req_angle,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic [FLOAT_DATA_WIDTH-1:0]         resp_result,
  output logic                                resp_error,
  output logic                                busy,
  output logic                                core_clk_en,
  output logic [FLOAT_DATA_WIDTH-1:0]         core_angle,
  input  logic                                core_done,
  input  logic [FLOAT_DATA_WIDTH-1:0]         core_result
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RESPOND = 2'd3;

  // The counter shows cycles already spent in WAIT, so the last allowed cycle is MAX-1.
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_MAX - 1);

  logic [1:0]                  state_q, state_d;
  logic [IDX_W-1:0]            last_q, last_d;
  logic [TIMEOUT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]          grant_q, grant_d;
  logic [NUM_REQ-1:0]          resp_valid_q, resp_valid_d;
  logic [FLOAT_DATA_WIDTH-1:0] resp_result_q, resp_result_d;
  logic [FLOAT_DATA_WIDTH-1:0] core_angle_q, core_angle_d;
  logic                        resp_error_q, resp_error_d;
  logic                        busy_q, busy_d;
  logic                        core_clk_en_q, core_clk_en_d;

  logic                        win_found;
  logic [IDX_W-1:0]            win_idx;
  logic [IDX_W-1:0]            cand;

  // Search starts just after the previous winner; the previous winner itself is checked last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = '0;
    core_angle_d  = core_angle_q;
    grant_d       = '0;
    core_clk_en_d = 1'b0;
    resp_valid_d  = '0;
    resp_result_d = '0;
    resp_error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d       = ST_ISSUE;
          last_d        = win_idx;
          core_angle_d  = req_angle[int'(win_idx)*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH];
          grant_d       = NUM_REQ'(1) << win_idx;
          core_clk_en_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done on the final timeout cycle still counts as a normal completion.
        if (core_done) begin
          state_d       = ST_RESPOND;
          resp_valid_d  = NUM_REQ'(1) << last_q;
          resp_result_d = core_result;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_RESPOND;
          resp_valid_d = NUM_REQ'(1) << last_q;
          resp_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      last_q        <= IDX_W'(NUM_REQ - 1);
      cnt_q         <= '0;
      grant_q       <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_error_q  <= 1'b0;
      busy_q        <= 1'b0;
      core_clk_en_q <= 1'b0;
      core_angle_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_error_q  <= resp_error_d;
      busy_q        <= busy_d;
      core_clk_en_q <= core_clk_en_d;
      core_angle_q  <= core_angle_d;
    end
  end

  assign grant       = grant_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_error  = resp_error_q;
  assign busy        = busy_q;
  assign core_clk_en = core_clk_en_q;
  assign core_angle  = core_angle_q;

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one CORDIC core.
REQ-002 Parameter FLOAT_DATA_WIDTH, default 32: width of the float angle and result.
REQ-003 Parameter TIMEOUT_WIDTH, default 10: width of the wait counter.
REQ-004 Parameter TIMEOUT_MAX, default 1023: number of WAIT cycles before the core is declared hung.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 req  input  NUM_REQ  per-requester request level; held high with its angle until granted.
REQ-009 req_angle  input  NUM_REQ*FLOAT_DATA_WIDTH  packed angles; requester i occupies slice [i*FLOAT_DATA_WIDTH +: FLOAT_DATA_WIDTH].
REQ-010 grant  output  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-011 resp_valid  output  NUM_REQ  one-hot, one-cycle response pulse to the owning requester.
REQ-012 resp_result  output  FLOAT_DATA_WIDTH  result, valid only while resp_valid is non-zero.
REQ-013 resp_error  output  1  timeout flag, valid only while resp_valid is non-zero.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 core_clk_en  output  1  one-cycle start pulse to the CORDIC core.
REQ-016 core_angle  output  FLOAT_DATA_WIDTH  registered angle presented to the core.
REQ-017 core_done  input  1  core completion strobe.
REQ-018 core_result  input  FLOAT_DATA_WIDTH  core result, sampled when core_done is high.

Function
REQ-019 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESPOND, with transitions IDLE->ISSUE->WAIT->RESPOND->IDLE.
REQ-020 IDLE: on the clock edge where req is non-zero, the winner SHALL be selected, its index and angle registered into core_angle, and the next state SHALL be ISSUE.
REQ-021 Arbitration SHALL be round-robin: the search starts at index last_winner+1 (mod NUM_REQ), and the first set req bit wins.
REQ-022 The round-robin pointer SHALL update only on a grant.
REQ-023 ISSUE lasts exactly one cycle, during which grant[winner] and core_clk_en are both high.
REQ-024 Requesters SHALL deassert req the cycle after grant; a req still high in RESPOND or IDLE is treated as a new request.
REQ-025 core_angle SHALL stay stable from ISSUE through RESPOND.
REQ-026 WAIT: the counter SHALL clear on entry and increment each cycle.
REQ-027 WAIT: on a cycle where core_done=1, the block SHALL capture core_result, set error=0 and go to RESPOND.
REQ-028 WAIT: when the counter reaches TIMEOUT_MAX with core_done=0, the block SHALL set the result to 0, set error=1 and go to RESPOND.
REQ-029 If core_done and the timeout occur in the same cycle, core_done SHALL win (error=0).
REQ-030 core_done outside WAIT SHALL be ignored.
REQ-031 RESPOND lasts exactly one cycle: resp_valid[winner]=1 with the captured resp_result and resp_error; the next state is IDLE.
REQ-032 resp_result and resp_error SHALL be 0 whenever resp_valid=0.
REQ-033 Minimum latency SHALL be core latency + 3 cycles: request-sample edge to ISSUE (1), ISSUE to WAIT (1), done edge to RESPOND (1).
REQ-034 At most one transaction SHALL be in flight, with no queueing inside the block.
REQ-035 A req withdrawn before it is sampled in IDLE SHALL produce no grant.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 While rst=0, state=IDLE, the pointer points so that requester 0 has top priority, and grant, resp_valid, resp_result, resp_error, busy, core_clk_en, core_angle and the counter are all 0.
REQ-038 Reset asserted mid-transaction SHALL abort the transaction with no resp_valid; any later core_done is ignored until a new ISSUE.
REQ-039 After rst returns to 1, the first arbitration SHALL occur on the first rising edge.

Verification
REQ-040 Single request: req=4'b0010, angle 0x3F000000, core_done 8 cycles after core_clk_en with result 0x3EF57744 -> grant=0010 and core_clk_en in one cycle; resp_valid=0010 with resp_result=0x3EF57744 and resp_error=0.
REQ-041 Round-robin: all four req held continuously -> grant order 0,1,2,3,0 after reset, with no requester granted twice before all are served.
REQ-042 Timeout: core_done never asserted, TIMEOUT_MAX=15 -> resp_valid exactly 15 WAIT cycles after entering WAIT, resp_error=1, resp_result=0.
REQ-043 Collision: core_done=1 on the TIMEOUT_MAX cycle -> resp_error=0 and the core result is returned.
REQ-044 Reset mid-WAIT: rst=0 for 1 cycle during WAIT, then core_done pulses -> no resp_valid, busy=0, next req granted normally.
REQ-045 Stray done: core_done pulsed in IDLE and ISSUE -> ignored, response taken only from the in-WAIT done.
